if_stage: RTL and testbench

Instruction-fetch stage with integrated IF/ID pipeline register for the multi-cycle/pipelined MIPS core. Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake with at most one request outstanding. Holds fetched words in a one-entry skid buffer plus the IF/ID register. Presents op and imm16 fields directly to the downstream immediate extender and decoder. Supports decode stall and branch/jump redirect.

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_skid_buf.sv | 38 +++
 rtl/if_stage.sv | 133 +++++++++++++
 tb/tb_if_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector, PC step,
// fetch FSM encoding and instruction field positions.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam int          PC_STEP_DEF  = 4;
  localparam int          INSTR_W      = 32;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_KILL = 2'd2
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry instruction/PC holding buffer that catches a fetch response
// arriving while the IF/ID register is stalled.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [31:0]        d_pc,
  output logic               full,
  output logic [INSTR_W-1:0] q_instr,
  output logic [31:0]        q_pc
);

  // Occupancy flag; a load in the same cycle as an unload keeps it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, skid buffer
// and the IF/ID register feeding decode and the immediate extender.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk_I,
  input  logic        rst_n_I,
  output logic        imem_req_O,
  output logic [31:0] imem_addr_O,
  input  logic        imem_gnt_I,
  input  logic        imem_rvalid_I,
  input  logic [31:0] imem_rdata_I,
  input  logic        stall_I,
  input  logic        redirect_I,
  input  logic [31:0] redirect_pc_I,
  output logic        valid_O,
  output logic [31:0] instr_O,
  output logic [31:0] pc_O,
  output logic [31:0] pc4_O,
  output logic [5:0]  op_O,
  output logic [15:0] imm16_O
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        fire;
  logic        rsp_acc;

  logic        vld_p1;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;

  logic        consume;
  logic        open;
  logic        skid_full;
  logic        skid_load;
  logic        skid_unload;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  // IF0: request issue, PC and outstanding-fetch tracking
  always_comb begin
    imem_req_O  = rst_n_I && (state_q == IF_IDLE) && !skid_full && !redirect_I;
    imem_addr_O = pc_q;
    fire        = imem_req_O && imem_gnt_I;
    rsp_acc     = (state_q == IF_WAIT) && imem_rvalid_I && !redirect_I;
    state_d     = state_q;
    case (state_q)
      IF_IDLE: if (fire) state_d = IF_WAIT;
      // A response completes the transaction even when a redirect drops it.
      IF_WAIT: begin
        if (imem_rvalid_I)   state_d = IF_IDLE;
        else if (redirect_I) state_d = IF_KILL;
      end
      IF_KILL: if (imem_rvalid_I) state_d = IF_IDLE;
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (redirect_I) begin
        pc_q <= word_align(redirect_pc_I);
      end else if (fire) begin
        pc_q <= pc_q + 32'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk_I) begin
    if (fire) begin
      req_pc_q <= pc_q;
    end
  end

  assign consume     = vld_p1 && !stall_I;
  assign open        = !vld_p1 || consume;
  assign skid_unload = open && skid_full && !redirect_I;
  // The skid only takes a response the IF/ID register cannot absorb directly.
  assign skid_load   = rsp_acc && !(open && !skid_full);

  if_skid_buf u_skid (
    .clk     (clk_I),
    .rst_n   (rst_n_I),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (redirect_I),
    .d_instr (imem_rdata_I),
    .d_pc    (req_pc_q),
    .full    (skid_full),
    .q_instr (skid_instr),
    .q_pc    (skid_pc)
  );

  // IF1: IF/ID register, skid contents take priority over a fresh response
  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else if (redirect_I) begin
      vld_p1 <= 1'b0;
    end else if (open) begin
      if (skid_full) begin
        vld_p1   <= 1'b1;
        instr_p1 <= skid_instr;
        pc_p1    <= skid_pc;
      end else if (rsp_acc) begin
        vld_p1   <= 1'b1;
        instr_p1 <= imem_rdata_I;
        pc_p1    <= req_pc_q;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign valid_O = vld_p1;
  assign instr_O = instr_p1;
  assign pc_O    = pc_p1;
  assign pc4_O   = pc_p1 + 32'd4;
  assign op_O    = instr_p1[OP_MSB:OP_LSB];
  assign imm16_O = instr_p1[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural instruction memory with programmable grant
// and response delays, plus an in-order scoreboard of consumed instructions.
module tb_if_stage;

  localparam logic [31:0] SPECIAL_PC = 32'h0000_1000;
  localparam logic [31:0] SPECIAL_W  = 32'h2008_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [5:0]  op;
  logic [15:0] imm16;

  logic        gnt_ok;
  int          errors = 0;
  int          checks = 0;
  int          gnt_dly = 0;
  int          rv_dly = 0;
  bit          hold_gnt = 1'b0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr;
  int          wait_cnt = 0;
  int          acc_cnt = 0;
  int          rv_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];

  typedef struct {
    logic [31:0] target;
    int          gdly;
    int          rdly;
    int          n;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  assign imem_gnt = imem_req & gnt_ok;

  if_stage dut (
    .clk_I         (clk),
    .rst_n_I       (rst_n),
    .imem_req_O    (imem_req),
    .imem_addr_O   (imem_addr),
    .imem_gnt_I    (imem_gnt),
    .imem_rvalid_I (imem_rvalid),
    .imem_rdata_I  (imem_rdata),
    .stall_I       (stall),
    .redirect_I    (redirect),
    .redirect_pc_I (redirect_pc),
    .valid_O       (valid),
    .instr_O       (instr),
    .pc_O          (pc),
    .pc4_O         (pc4),
    .op_O          (op),
    .imm16_O       (imm16)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == SPECIAL_PC) ? SPECIAL_W : a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rst();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'hBFC0_0000);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc",    pc, 32'd0);
    check("rst_pc4",   pc4, 32'd4);
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic clear_sb();
    exp_q.delete();
    log_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    #4;
    check_rst();
    @(negedge clk);
    rst_n = 1'b1;
    clear_sb();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (log_q.size() >= n) break;
    end
    check({name, "_count"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  // Instruction memory: grant after gnt_dly refused cycles, data = address.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    gnt_ok      = 1'b0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend = 1'b0;
          rv_cnt++;
        end else begin
          pend_cnt--;
        end
      end
      gnt_ok = !hold_gnt && (wait_cnt >= gnt_dly);
      #4;
      if (imem_req === 1'b1) begin
        if (imem_gnt === 1'b1) begin
          check("one_outstanding", {31'd0, pend}, 32'd0);
          pend      = 1'b1;
          pend_cnt  = rv_dly;
          pend_addr = imem_addr;
          acc_cnt++;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Scoreboard: every instruction decode takes must be the next expected one.
  initial begin
    logic [31:0] e;
    logic [31:0] ew;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && !redirect && !stall && (valid === 1'b1)) begin
        log_q.push_back(pc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h expected none", pc);
        end else begin
          e  = exp_q.pop_front();
          ew = mem_word(e);
          check("sb_pc",    pc, e);
          check("sb_instr", instr, ew);
          check("sb_pc4",   pc4, e + 32'd4);
          check("sb_op",    {26'd0, op}, {26'd0, ew[31:26]});
          check("sb_imm16", {16'd0, imm16}, {16'd0, ew[15:0]});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    vecs[0] = '{32'h8000_0102, 0, 0, 4, 32'h8000_0100, 32'h8000_010C};
    vecs[1] = '{32'hFFFF_FFFC, 0, 0, 2, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h0000_2003, 1, 0, 3, 32'h0000_2000, 32'h0000_2008};
    vecs[3] = '{32'h1234_5678, 2, 1, 3, 32'h1234_5678, 32'h1234_5680};

    // Zero-wait memory straight out of reset.
    gnt_dly = 0;
    rv_dly = 0;
    do_reset();
    push_seq(32'hBFC0_0000, 40);
    #4;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'hBFC0_0000);
    @(negedge clk); #4;
    check("lat_c1_valid", {31'd0, valid}, 32'd0);
    @(negedge clk); #4;
    check("lat_c2_valid", {31'd0, valid}, 32'd1);
    check("lat_c2_pc", pc, 32'hBFC0_0000);
    check("lat_c2_pc4", pc4, 32'hBFC0_0004);
    wait_log(8, 100, "zw");
    if (log_q.size() >= 8) check("zw_8th_pc", log_q[7], 32'hBFC0_001C);

    // Grant withheld for three cycles.
    gnt_dly = 3;
    do_reset();
    push_seq(32'hBFC0_0000, 40);
    a0 = acc_cnt;
    for (int k = 0; k < 4; k++) begin
      #4;
      check("gdly_req", {31'd0, imem_req}, 32'd1);
      check("gdly_addr", imem_addr, 32'hBFC0_0000);
      @(negedge clk);
    end
    check("gdly_one_fetch", 32'(acc_cnt - a0), 32'd1);
    wait_log(2, 100, "gdly");
    if (log_q.size() >= 2) check("gdly_no_dup", log_q[1], 32'hBFC0_0004);

    // Redirect targets under various memory timings.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      gnt_dly = vecs[v].gdly;
      rv_dly = vecs[v].rdly;
      redirect = 1'b1;
      redirect_pc = vecs[v].target;
      clear_sb();
      push_seq(vecs[v].first, vecs[v].n + 32);
      @(negedge clk);
      redirect = 1'b0;
      wait_log(vecs[v].n, 300, "vec");
      if (log_q.size() >= vecs[v].n) begin
        check("vec_first", log_q[0], vecs[v].first);
        check("vec_last", log_q[vecs[v].n - 1], vecs[v].last);
      end
    end

    // Decode stall with 0x2008FFFF held in IF/ID and the next word in the skid.
    @(negedge clk);
    gnt_dly = 0;
    rv_dly = 0;
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = SPECIAL_PC;
    clear_sb();
    push_seq(SPECIAL_PC, 40);
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid === 1'b1) break;
      @(negedge clk);
    end
    check("stall_valid", {31'd0, valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) a0 = acc_cnt;
      #4;
      check("stall_hold_instr", instr, SPECIAL_W);
      if (k == 0) begin
        check("stall_op", {26'd0, op}, 32'h0000_0008);
        check("stall_imm16", {16'd0, imm16}, 32'h0000_FFFF);
      end
      if (k == 4) check("stall_skid_no_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
    end
    check("stall_no_fetch", 32'(acc_cnt - a0), 32'd0);
    stall = 1'b0;
    wait_log(2, 50, "stall");
    if (log_q.size() >= 2) begin
      check("stall_rel_first", log_q[0], SPECIAL_PC);
      check("stall_rel_skid", log_q[1], SPECIAL_PC + 32'd4);
    end

    // Redirect while a slow response is outstanding.
    @(negedge clk);
    rv_dly = 2;
    a0 = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_cnt != a0) break;
    end
    redirect = 1'b1;
    redirect_pc = 32'h8000_0102;
    clear_sb();
    push_seq(32'h8000_0100, 40);
    @(negedge clk);
    redirect = 1'b0;
    #4;
    check("kill_valid", {31'd0, valid}, 32'd0);
    check("kill_no_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #4;
      if (imem_req === 1'b1) break;
    end
    check("kill_req", {31'd0, imem_req}, 32'd1);
    check("kill_addr", imem_addr, 32'h8000_0100);
    check("kill_dropped", {31'd0, valid}, 32'd0);
    wait_log(2, 100, "kill");

    // Reset while waiting; the stale response must be ignored.
    @(negedge clk);
    rv_dly = 3;
    a0 = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_cnt != a0) break;
    end
    rst_n = 1'b0;
    hold_gnt = 1'b1;
    #4;
    check_rst();
    @(negedge clk);
    rst_n = 1'b1;
    clear_sb();
    push_seq(32'hBFC0_0000, 40);
    a0 = rv_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rv_cnt != a0) break;
    end
    check("stale_rvalid_seen", 32'(rv_cnt - a0), 32'd1);
    @(negedge clk);
    hold_gnt = 1'b0;
    #4;
    check("stale_ignored", {31'd0, valid}, 32'd0);
    check("stale_req", {31'd0, imem_req}, 32'd1);
    check("stale_addr", imem_addr, 32'hBFC0_0000);
    wait_log(2, 100, "stale");
    if (log_q.size() >= 1) check("stale_first_pc", log_q[0], 32'hBFC0_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
